jt51_timer_mmr: RTL
===================

Name: jt51_timer_mmr

Overview:
CPU-side register front end for the timer pair: the writer/reader end of the timer control interface. Decodes YM2151-style address/data port writes to registers 0x10, 0x11, 0x12 and 0x14 into timer A/B start values, load levels, IRQ enables and one-cycle flag-clear pulses. Returns the status byte (busy, flag_B, flag_A) on reads. Models the chip busy window after each data write. Sits between the host bus and the timer block.

Parameters:
BUSY_CYCLES, 32, number of cen&&zero ticks that busy stays high after an accepted data write (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
cen  in  1  clock enable, shared with the timers
zero  in  1  sample tick, shared with the timers; the busy countdown advances on cen&&zero
cs_n  in  1  chip select, active low
wr_n  in  1  write strobe, active low
a0  in  1  port select: 0 = address port, 1 = data port
din  in  8  write data
dout  out  8  status byte {busy, 5'b0, flag_B, flag_A}
flag_A  in  1  timer A flag from the timers
flag_B  in  1  timer B flag from the timers
value_A  out  10  timer A start value
value_B  out  8  timer B start value
load_A  out  1  timer A load/run level
load_B  out  1  timer B load/run level
enable_irq_A  out  1  IRQ enable, timer A
enable_irq_B  out  1  IRQ enable, timer B
clr_flag_A  out  1  one-clk pulse that clears flag A
clr_flag_B  out  1  one-clk pulse that clears flag B
csm  out  1  register 0x14 bit 7, stored and exported only
busy  out  1  write-busy status

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs go to 0.
  - Address latch is 0.
  - FSM goes to IDLE.
  - Busy counter is 0.
  - Reset overrides any write or countdown in progress, including mid-busy.
- Write detection:
  - we = ~cs_n & ~wr_n, registered as last_we.
  - An access fires once, on the clk cycle where we=1 and last_we=0.
  - A held strobe never repeats the access.
  - Strobes are synchronous to clk; input synchronisation is out of scope.
- Address write (a0=0): addr <= din. Accepted in every FSM state, including BUSY.
- Data write (a0=1): accepted only in IDLE. In WRITE or BUSY it is silently dropped; no register changes.
- FSM:
  - IDLE -> WRITE on an accepted data write. data and addr are captured.
  - WRITE, one clk: apply the register update. busy <= 1. Counter <= BUSY_CYCLES. -> BUSY.
  - BUSY: on each cen&&zero tick the counter decrements. When the counter is 1 and a tick occurs, the counter goes to 0, busy <= 0 and the FSM -> IDLE.
  - busy is therefore high from the WRITE cycle until the BUSY_CYCLES-th tick.
- Register map, applied in WRITE:
  - 0x10: value_A[9:2] <= data.
  - 0x11: value_A[1:0] <= data[1:0].
  - 0x12: value_B <= data.
  - 0x14:
    - csm <= d[7].
    - clr_flag_B <= d[5], clr_flag_A <= d[4], both as one-clk pulses.
    - enable_irq_B <= d[3], enable_irq_A <= d[2].
    - load_B <= d[1], load_A <= d[0].
  - Any other address: the write completes and busy still asserts, but no timer state changes.
- clr_flag_A and clr_flag_B are high for exactly the WRITE cycle and 0 in every other state.
- Load levels persist until the next 0x14 write. The timers edge-detect them.
- Status read: dout is registered every clk as {busy, 5'b0, flag_B, flag_A}. It is independent of cs_n, a0 and wr_n (1-clk latency).
- cen and zero gate only the busy countdown. Register updates and pulses run on clk.

Decomposition:
- Shared package jt51_timer_pkg:
  - register address constants TMR_CLKA1=8'h10, TMR_CLKA2=8'h11, TMR_CLKB=8'h12, TMR_CTRL=8'h14;
  - control bit index constants for 0x14;
  - FSM state enum {IDLE, WRITE, BUSY}.
- One natural sub-module: jt51_busy_cnt. It holds the busy countdown, with inputs start and tick and output busy.

Test Plan:
- Reset: rst high for 2 clks while a data write is in progress -> all outputs 0, dout=8'h00, FSM IDLE.
- Timer A value: addr 0x10 <- 0xAB; wait until busy=0; addr 0x11 <- 0x03 -> value_A=10'h2AF. busy is high for exactly 32 cen&&zero ticks after each write.
- Control: addr 0x14 <- 0x3F -> in the WRITE cycle, clr_flag_A=1 and clr_flag_B=1 for exactly 1 clk. Then load_A=1, load_B=1, enable_irq_A=1, enable_irq_B=1, csm=0.
- Dropped write: addr 0x12 <- 0x55; during busy, a data write of 0x77 -> value_B stays 0x55. busy timing is unchanged and not extended.
- Held strobe: cs_n and wr_n held low for 10 clks on data 0x12 <- 0x10 -> exactly one write, one busy window.
- Status: flag_A=1, flag_B=0 during busy -> dout=8'h81 one clk later. After busy clears -> dout=8'h01. Reset asserted mid-busy -> busy=0 on the next clk.

Source files
------------

// File: rtl/jt51_timer_pkg.sv
// Shared constants and types for the jt51 timer register front end.
package jt51_timer_pkg;

  // Timer register addresses
  localparam logic [7:0] TMR_CLKA1 = 8'h10;
  localparam logic [7:0] TMR_CLKA2 = 8'h11;
  localparam logic [7:0] TMR_CLKB  = 8'h12;
  localparam logic [7:0] TMR_CTRL  = 8'h14;

  // Bit positions inside the 0x14 control register
  localparam int unsigned CTRL_CSM    = 7;
  localparam int unsigned CTRL_CLR_B  = 5;
  localparam int unsigned CTRL_CLR_A  = 4;
  localparam int unsigned CTRL_IRQ_B  = 3;
  localparam int unsigned CTRL_IRQ_A  = 2;
  localparam int unsigned CTRL_LOAD_B = 1;
  localparam int unsigned CTRL_LOAD_A = 0;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StBusy
  } tmr_state_e;

endpackage

// File: rtl/jt51_busy_cnt.sv
// Busy window countdown: loads on start, counts down on each tick, busy while non-zero.
module jt51_busy_cnt #(
  parameter int unsigned BUSY_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic tick,
  output logic busy,
  output logic done
);

  localparam logic [7:0] LoadVal = 8'(BUSY_CYCLES);

  logic [7:0] cnt_q, cnt_d;

  // Next count: a fresh start wins over a coincident tick
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = LoadVal;
    end else if (tick && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != 8'd0);
  // Final tick of the window; the FSM uses it to return to idle
  assign done = tick && (cnt_q == 8'd1) && !start;

endmodule

// File: rtl/jt51_timer_mmr.sv
// CPU-side register front end for the timer pair: decodes address/data port writes
// into timer controls, reports status and models the post-write busy window.
module jt51_timer_mmr
  import jt51_timer_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       zero,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       flag_A,
  input  logic       flag_B,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic       csm,
  output logic       busy
);

  tmr_state_e state_q, state_d;

  logic       last_we_q;
  logic [7:0] addr_q;
  logic [7:0] waddr_q;
  logic [7:0] wdata_q;
  logic [9:0] value_a_q;
  logic [7:0] value_b_q;
  logic       load_a_q, load_b_q;
  logic       irq_a_q, irq_b_q;
  logic       csm_q;
  logic [7:0] dout_q;

  logic we, wr_pulse, data_wr, start, cnt_done, in_write, ctrl_write;

  assign we       = ~cs_n & ~wr_n;
  assign wr_pulse = we & ~last_we_q;
  // Data writes are only taken when no earlier write is still being processed
  assign data_wr  = wr_pulse & a0 & (state_q == StIdle);
  assign in_write = (state_q == StWrite);
  assign ctrl_write = in_write && (waddr_q == TMR_CTRL);

  jt51_busy_cnt #(
    .BUSY_CYCLES(BUSY_CYCLES)
  ) u_busy_cnt (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .tick (cen & zero),
    .busy (busy),
    .done (cnt_done)
  );

  // FSM next state; start loads the busy counter during the write cycle
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      StIdle:  if (data_wr) state_d = StWrite;
      StWrite: begin
        start   = 1'b1;
        state_d = StBusy;
      end
      StBusy:  if (cnt_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, bus latches, timer registers and status byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_we_q <= 1'b0;
      addr_q    <= 8'd0;
      waddr_q   <= 8'd0;
      wdata_q   <= 8'd0;
      value_a_q <= 10'd0;
      value_b_q <= 8'd0;
      load_a_q  <= 1'b0;
      load_b_q  <= 1'b0;
      irq_a_q   <= 1'b0;
      irq_b_q   <= 1'b0;
      csm_q     <= 1'b0;
      dout_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      last_we_q <= we;
      dout_q    <= {busy, 5'b0, flag_B, flag_A};
      if (wr_pulse && !a0) addr_q <= din;
      if (data_wr) begin
        waddr_q <= addr_q;
        wdata_q <= din;
      end
      if (in_write) begin
        case (waddr_q)
          TMR_CLKA1: value_a_q[9:2] <= wdata_q;
          TMR_CLKA2: value_a_q[1:0] <= wdata_q[1:0];
          TMR_CLKB:  value_b_q      <= wdata_q;
          TMR_CTRL: begin
            csm_q    <= wdata_q[CTRL_CSM];
            irq_b_q  <= wdata_q[CTRL_IRQ_B];
            irq_a_q  <= wdata_q[CTRL_IRQ_A];
            load_b_q <= wdata_q[CTRL_LOAD_B];
            load_a_q <= wdata_q[CTRL_LOAD_A];
          end
          default: ;
        endcase
      end
    end
  end

  // Flag clears are only high while the control write is being applied
  assign clr_flag_A   = ctrl_write && wdata_q[CTRL_CLR_A];
  assign clr_flag_B   = ctrl_write && wdata_q[CTRL_CLR_B];
  assign value_A      = value_a_q;
  assign value_B      = value_b_q;
  assign load_A       = load_a_q;
  assign load_B       = load_b_q;
  assign enable_irq_A = irq_a_q;
  assign enable_irq_B = irq_b_q;
  assign csm          = csm_q;
  assign dout         = dout_q;

endmodule
